aes_dec_iter: RTL and testbench

//  Iterative, handshaked AES decryption core for 128/192/256-bit keys. It reuses
//  the existing key_gen schedule (decryption order) and dec_round logic.
//  It computes RPC rounds per clock instead of unrolling all rounds.

---
 rtl/aes_dec_iter.sv | 264 ++++++++++++++++++++++++++
 tb/tb_aes_dec_iter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_iter.sv
// Iterative AES decryption core: RPC inverse rounds per clock over a decryption-ordered key schedule.
// Valid/ready on both sides, back-to-back blocks, synchronous flush and asynchronous active-low reset.
module aes_dec_iter #(
    parameter int KEY_SIZE = 128,
    parameter int RPC      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        ct,
    input  logic [KEY_SIZE-1:0] key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        pt,
    output logic                busy
);
    localparam int ROUNDS = (KEY_SIZE == 128) ? 10 : (KEY_SIZE == 192) ? 12 : 14;

    generate
        if (!(KEY_SIZE == 128 || KEY_SIZE == 192 || KEY_SIZE == 256)) begin : g_bad_key
            $error("aes_dec_iter: KEY_SIZE must be 128, 192 or 256");
        end
        if (!(RPC == 1 || RPC == 2)) begin : g_bad_rpc
            $error("aes_dec_iter: RPC must be 1 or 2");
        end
    endgenerate

    // Handshake: a transfer happens on a rising clk edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [127:0]                 ct_reg, st;
    logic [KEY_SIZE-1:0]          key_reg;
    logic [3:0]                   rnd;
    logic [128*(ROUNDS+1)-1:0]    w;
    logic [127:0]                 rk [0:ROUNDS];
    logic [127:0]                 fin_out, result;
    logic                         accept, last;

    key_gen #(.KEY_SIZE(KEY_SIZE), .ROUNDS(ROUNDS)) u_key_gen (.key(key_reg), .w(w));

    for (genvar k = 0; k <= ROUNDS; k++) begin : g_rk
        assign rk[k] = w[128*k +: 128];
    end

    // Chain of generic rounds; the final unit taps the input of the last stage.
    for (genvar j = 0; j < RPC; j++) begin : g_stage
        logic [127:0] din, dout;
        logic [3:0]   idx;
        if (j == 0) begin : g_first
            assign din = st;
        end else begin : g_next
            assign din = g_stage[j-1].dout;
        end
        assign idx = rnd + 4'(j);
        dec_round #(.ROUND(1), .ROUNDS(ROUNDS)) u_gen (.din(din), .rk(rk[idx]), .dout(dout));
    end

    dec_round #(.ROUND(ROUNDS), .ROUNDS(ROUNDS)) u_fin (
        .din(g_stage[RPC-1].din), .rk(rk[ROUNDS]), .dout(fin_out));

    assign last   = (rnd + 4'(RPC - 1)) == 4'(ROUNDS);
    assign result = last ? fin_out : g_stage[RPC-1].dout;
    assign accept = in_valid & in_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nx = LOAD;
                LOAD:    state_nx = RUN;
                RUN:     if (last) state_nx = DONE;
                DONE:    if (out_ready) state_nx = in_valid ? LOAD : IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        busy      = (state == LOAD) | (state == RUN);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ct_reg  <= '0;
            key_reg <= '0;
            st      <= '0;
            pt      <= '0;
            rnd     <= '0;
        end else if (flush) begin
            rnd <= '0;
            pt  <= '0;
        end else begin
            if (accept) begin
                ct_reg  <= ct;
                key_reg <= key;
            end
            case (state)
                LOAD: begin
                    st  <= ct_reg ^ rk[0];
                    rnd <= 4'd1;
                end
                RUN: begin
                    rnd <= rnd + 4'(RPC);
                    if (last) pt <= result;
                    else      st <= result;
                end
                default: ;
            endcase
        end
    end
endmodule

// Key expansion; round key k of w is encryption round key ROUNDS-k.
module key_gen #(
    parameter int KEY_SIZE = 128,
    parameter int ROUNDS   = 10
) (
    input  logic [KEY_SIZE-1:0]       key,
    output logic [128*(ROUNDS+1)-1:0] w
);
    localparam int NK = KEY_SIZE / 32;
    localparam int NW = 4 * (ROUNDS + 1);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        t = ginv(x);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]} ^ {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] v);
        return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
    endfunction

    logic [31:0] ew [0:NW-1];
    logic [31:0] tmp;
    logic [7:0]  rcon;

    always_comb begin
        ew   = '{default: '0};
        tmp  = '0;
        rcon = 8'h01;
        w    = '0;
        for (int i = 0; i < NK; i++) ew[i] = key[KEY_SIZE-1-32*i -: 32];
        for (int i = NK; i < NW; i++) begin
            tmp = ew[i-1];
            if (i % NK == 0) begin
                tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
                rcon = xt(rcon);
            end else if (NK > 6 && i % NK == 4) begin
                tmp = sub_word(tmp);
            end
            ew[i] = ew[i-NK] ^ tmp;
        end
        for (int k = 0; k <= ROUNDS; k++) begin
            w[128*k +: 128] = {ew[4*(ROUNDS-k)], ew[4*(ROUNDS-k)+1],
                               ew[4*(ROUNDS-k)+2], ew[4*(ROUNDS-k)+3]};
        end
    end
endmodule

// One inverse-cipher round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless final.
module dec_round #(
    parameter int ROUND  = 1,
    parameter int ROUNDS = 10
) (
    input  logic [127:0] din,
    input  logic [127:0] rk,
    output logic [127:0] dout
);
    localparam bit LAST = (ROUND == ROUNDS);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    logic [7:0] a [0:15];

    always_comb begin
        a    = '{default: '0};
        dout = '0;
        // Byte (row r, column c) lives at index 4c+r; row r is rotated right by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[4*c+r] = inv_sbox(din[127-8*(4*((c+4-r)%4)+r) -: 8]) ^ rk[127-8*(4*c+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (LAST) begin
                dout[127-32*c -: 32] = {a[4*c], a[4*c+1], a[4*c+2], a[4*c+3]};
            end else begin
                dout[127-32*c -: 32] = {
                    gmul(a[4*c], 8'd14) ^ gmul(a[4*c+1], 8'd11) ^ gmul(a[4*c+2], 8'd13) ^ gmul(a[4*c+3], 8'd9),
                    gmul(a[4*c], 8'd9)  ^ gmul(a[4*c+1], 8'd14) ^ gmul(a[4*c+2], 8'd11) ^ gmul(a[4*c+3], 8'd13),
                    gmul(a[4*c], 8'd13) ^ gmul(a[4*c+1], 8'd9)  ^ gmul(a[4*c+2], 8'd14) ^ gmul(a[4*c+3], 8'd11),
                    gmul(a[4*c], 8'd11) ^ gmul(a[4*c+1], 8'd13) ^ gmul(a[4*c+2], 8'd9)  ^ gmul(a[4*c+3], 8'd14)};
            end
        end
    end
endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: FIPS-197 / SP800-38A vectors, latency, backpressure,
// back-to-back throughput, flush, asynchronous reset and input changes during a block.
module tb_aes_dec_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [3:0]        flush_v, in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
    logic [3:0][127:0] ct_v, pt_v;
    logic [3:0][255:0] key_v;

    int n_vec = 0;
    int n_err = 0;

    // Instance 0: 128/RPC1 (main), 1: 128/RPC2, 2: 192/RPC1, 3: 256/RPC1.
    aes_dec_iter #(.KEY_SIZE(128), .RPC(1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .ct(ct_v[0]), .key(key_v[0][127:0]), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .pt(pt_v[0]), .busy(busy_v[0]));
    aes_dec_iter #(.KEY_SIZE(128), .RPC(2)) u_dut_r2 (
        .clk(clk), .rst(rst), .flush(flush_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .ct(ct_v[1]), .key(key_v[1][127:0]), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .pt(pt_v[1]), .busy(busy_v[1]));
    aes_dec_iter #(.KEY_SIZE(192), .RPC(1)) u_dut_192 (
        .clk(clk), .rst(rst), .flush(flush_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .ct(ct_v[2]), .key(key_v[2][191:0]), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .pt(pt_v[2]), .busy(busy_v[2]));
    aes_dec_iter #(.KEY_SIZE(256), .RPC(1)) u_dut_256 (
        .clk(clk), .rst(rst), .flush(flush_v[3]), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .ct(ct_v[3]), .key(key_v[3]), .out_valid(out_valid_v[3]), .out_ready(out_ready_v[3]),
        .pt(pt_v[3]), .busy(busy_v[3]));

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [127:0] bb_ct  [3];
    logic [127:0] bb_pt  [3];
    logic [255:0] bb_key [3];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] junk128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [255:0] junk256();
        return {junk128(), junk128()};
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic start_block(input int d, input logic [127:0] c, input logic [255:0] k, input string tag);
        int waitc = 0;
        while (in_ready_v[d] !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " in_ready before accept"}, in_ready_v[d], 1'b1);
        in_valid_v[d] = 1'b1;
        ct_v[d]       = c;
        key_v[d]      = k;
        @(negedge clk);
        in_valid_v[d] = 1'b0;
    endtask

    // Scrambles ct/key and offers junk while the core is busy, then checks latency and result.
    task automatic run_to_done(input int d, input int exp_lat, input logic [127:0] exp_pt, input string tag);
        int lat = 0;
        while (out_valid_v[d] !== 1'b1 && lat < 60) begin
            chk({tag, " in_ready while busy"}, in_ready_v[d], 1'b0);
            chk({tag, " busy while running"}, busy_v[d], 1'b1);
            in_valid_v[d] = 1'b1;
            ct_v[d]       = junk128();
            key_v[d]      = junk256();
            @(negedge clk);
            lat++;
        end
        in_valid_v[d] = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " pt"}, pt_v[d], exp_pt);
        chk({tag, " busy with out_valid"}, busy_v[d], 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, got, last_done;

        bb_ct[0] = CT_128;                                   bb_key[0] = KEY_128;
        bb_pt[0] = FIPS_PT;
        bb_ct[1] = 128'h3925841d02dc09fbdc118597196a0b32;   bb_key[1] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        bb_pt[1] = 128'h3243f6a8885a308d313198a2e0370734;
        bb_ct[2] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;   bb_key[2] = 256'h2b7e151628aed2a6abf7158809cf4f3c;
        bb_pt[2] = 128'h6bc1bee22e409f96e93d7e117393172a;

        // Clock/reset
        flush_v = '0; in_valid_v = '0; out_ready_v = 4'b1110; ct_v = '0; key_v = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready_v[0], 1'b1);
        chk("reset out_valid", out_valid_v[0], 1'b0);
        chk("reset busy", busy_v[0], 1'b0);
        chk("reset pt", pt_v[0], 128'h0);
        rst = 1'b1;
        @(negedge clk);

        // AES-128 with backpressure on the output
        start_block(0, CT_128, KEY_128, "aes128");
        run_to_done(0, 11, FIPS_PT, "aes128");
        for (int i = 0; i < 20; i++) begin
            in_valid_v[0] = 1'b1;
            ct_v[0]       = junk128();
            key_v[0]      = junk256();
            @(negedge clk);
            chk("hold out_valid", out_valid_v[0], 1'b1);
            chk("hold pt", pt_v[0], FIPS_PT);
            chk("hold in_ready", in_ready_v[0], 1'b0);
            chk("hold busy", busy_v[0], 1'b0);
        end
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        #1;
        chk("release in_ready", in_ready_v[0], 1'b1);
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        chk("release out_valid", out_valid_v[0], 1'b0);
        chk("release busy", busy_v[0], 1'b0);
        chk("release pt kept", pt_v[0], FIPS_PT);

        // Other key sizes and two rounds per clock
        start_block(1, CT_128, KEY_128, "aes128 rpc2");
        run_to_done(1, 6, FIPS_PT, "aes128 rpc2");
        start_block(2, CT_192, KEY_192, "aes192");
        run_to_done(2, 13, FIPS_PT, "aes192");
        start_block(3, CT_256, KEY_256, "aes256");
        run_to_done(3, 15, FIPS_PT, "aes256");

        // Back-to-back with in_valid and out_ready held high
        out_ready_v[0] = 1'b1;
        chk("b2b idle in_ready", in_ready_v[0], 1'b1);
        in_valid_v[0] = 1'b1;
        ct_v[0] = bb_ct[0]; key_v[0] = bb_key[0];
        @(negedge clk);
        ct_v[0] = bb_ct[1]; key_v[0] = bb_key[1];
        cyc = 0; got = 0; last_done = 0;
        while (got < 3 && cyc < 100) begin
            if (out_valid_v[0] === 1'b1) begin
                chk("b2b pt", pt_v[0], bb_pt[got]);
                chk("b2b in_ready on done", in_ready_v[0], 1'b1);
                chk("b2b spacing", cyc - last_done, (got == 0) ? 11 : 12);
                last_done = cyc;
                got++;
                @(negedge clk);
                cyc++;
                if (got == 1) begin
                    ct_v[0] = bb_ct[2]; key_v[0] = bb_key[2];
                end else if (got == 2) begin
                    in_valid_v[0] = 1'b0;
                end
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("b2b blocks received", got, 3);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b0;
        @(negedge clk);

        // Flush at rnd=5, including a flush cycle with in_valid offered in IDLE
        start_block(0, bb_ct[1], bb_key[1], "flush");
        repeat (5) @(negedge clk);
        flush_v[0] = 1'b1;
        @(negedge clk);
        chk("flush busy", busy_v[0], 1'b0);
        chk("flush out_valid", out_valid_v[0], 1'b0);
        chk("flush pt", pt_v[0], 128'h0);
        chk("flush in_ready", in_ready_v[0], 1'b1);
        in_valid_v[0] = 1'b1;
        ct_v[0] = bb_ct[0]; key_v[0] = bb_key[0];
        @(negedge clk);
        chk("flush blocks accept", busy_v[0], 1'b0);
        flush_v[0]    = 1'b0;
        in_valid_v[0] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("after flush out_valid", out_valid_v[0], 1'b0);
        end
        start_block(0, bb_ct[0], bb_key[0], "post flush");
        run_to_done(0, 11, bb_pt[0], "post flush");
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        chk("post flush drained", out_valid_v[0], 1'b0);

        // Asynchronous reset at rnd=3
        start_block(0, bb_ct[2], bb_key[2], "reset mid");
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("async reset out_valid", out_valid_v[0], 1'b0);
        chk("async reset busy", busy_v[0], 1'b0);
        chk("async reset pt", pt_v[0], 128'h0);
        chk("async reset in_ready", in_ready_v[0], 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b1;
        start_block(0, bb_ct[2], bb_key[2], "post reset");
        run_to_done(0, 11, bb_pt[2], "post reset");
        @(negedge clk);
        chk("post reset idle", out_valid_v[0], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
